// File: rtl/sign_calc_pkg.sv
// sign_calc_pkg: shared mode codes, sign bit indices, FSM states and result width
package sign_calc_pkg;
  localparam int RES_W = 8;
  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_MUL = 2'd2;
  localparam logic [1:0] MODE_DIV = 2'd3;
  localparam int SGN_A = 0;
  localparam int SGN_B = 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
endpackage

// File: rtl/sign_calc_arbiter_if.sv
// sign_calc_arbiter_if: requester, engine and response signals of the shared calculator
interface sign_calc_arbiter_if
  import sign_calc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0] req, gnt;
  logic [2*NUM_REQ-1:0] req_m, req_s;
  logic [4*NUM_REQ-1:0] req_a, req_b;
  logic busy, calc_start, calc_done, rsp_valid, rsp_err;
  logic [1:0] calc_m, calc_s;
  logic [3:0] calc_a, calc_b;
  logic [RES_W-1:0] calc_result, rsp_result;
  logic [ID_W-1:0] rsp_id;
  modport master (
    output req, req_m, req_s, req_a, req_b, calc_done, calc_result,
    input gnt, busy, calc_start, calc_m, calc_s, calc_a, calc_b, rsp_valid, rsp_id, rsp_result, rsp_err
  );
  modport slave (
    input req, req_m, req_s, req_a, req_b, calc_done, calc_result,
    output gnt, busy, calc_start, calc_m, calc_s, calc_a, calc_b, rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/sign_calc_rr_pick.sv
// sign_calc_rr_pick: round-robin pick of the first request after ptr, as one-hot and index
module sign_calc_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  int best, d;
  always_comb begin
    best = N;
    d = 0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      d = (i + 2 * N - int'(ptr) - 1) % N;
      if (req[i] && d < best) begin
        best = d;
        idx = W'(i);
      end
    end
    gnt = (best < N) ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/sign_calc_arbiter.sv
// sign_calc_arbiter: round-robin sharing of one signed calculator engine with div0 trap and timeout
module sign_calc_arbiter
  import sign_calc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic Clear,
  sign_calc_arbiter_if.slave bus
);
  state_e state;
  logic [ID_W-1:0] ptr, idx, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [7:0] timer;
  logic [RES_W-1:0] res;
  logic err;
  sign_calc_rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .req(bus.req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      state <= IDLE;
      ptr <= ID_W'(NUM_REQ - 1);
      idx <= '0;
      timer <= '0;
      res <= '0;
      err <= 1'b0;
      bus.gnt <= '0;
      bus.busy <= 1'b0;
      bus.calc_start <= 1'b0;
      bus.calc_m <= '0;
      bus.calc_s <= '0;
      bus.calc_a <= '0;
      bus.calc_b <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_result <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      bus.gnt <= '0;
      bus.calc_start <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: if (|bus.req) begin
          bus.gnt <= pick_gnt;
          idx <= pick_idx;
          bus.calc_m <= bus.req_m[2*pick_idx +: 2];
          bus.calc_s <= bus.req_s[2*pick_idx +: 2];
          bus.calc_a <= bus.req_a[4*pick_idx +: 4];
          bus.calc_b <= bus.req_b[4*pick_idx +: 4];
          bus.busy <= 1'b1;
          state <= ISSUE;
        end
        // B magnitude zero is zero whatever its sign bit says
        ISSUE: if (bus.calc_m == MODE_DIV && bus.calc_b == 4'd0) begin
          res <= '0;
          err <= 1'b1;
          state <= RESP;
        end else begin
          bus.calc_start <= 1'b1;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: if (bus.calc_done) begin
          res <= bus.calc_result;
          err <= 1'b0;
          state <= RESP;
        end else begin
          timer <= timer + 8'd1;
          if (timer == 8'(TIMEOUT - 1)) begin
            res <= '0;
            err <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_id <= idx;
          bus.rsp_result <= res;
          bus.rsp_err <= err;
          bus.busy <= 1'b0;
          ptr <= idx;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sign_calc_arbiter.sv
// tb_sign_calc_arbiter: scoreboard bench with a small engine model driving calc_done
module tb_sign_calc_arbiter;
  import sign_calc_pkg::*;
  localparam int NUM_REQ = 4;
  localparam int ID_W = 2;
  localparam int TIMEOUT = 15;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [RES_W-1:0] res;
    logic err;
  } exp_t;
  logic clk = 1'b0;
  logic Clear = 1'b1;
  int n_chk = 0, n_fail = 0, cyc = 0, eng_k = 1, starts = 0, st = 0;
  int g_cyc = 0, s_cyc = 0, r_cyc = 0;
  exp_t sb[$];
  exp_t e;
  int gnt_q[$], gcyc_q[$];
  sign_calc_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();
  sign_calc_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .Clear(Clear),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] calc(input logic [1:0] m, input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
    int x, y;
    x = s[SGN_A] ? -int'(a) : int'(a);
    y = s[SGN_B] ? -int'(b) : int'(b);
    case (m)
      MODE_ADD: return 8'(x + y);
      MODE_SUB: return 8'(x - y);
      MODE_MUL: return 8'(x * y);
      default:  return (y == 0) ? 8'h00 : 8'(x / y);
    endcase
  endfunction
  function automatic logic [31:0] outs();
    return 32'({bus.gnt, bus.busy, bus.calc_start, bus.calc_m, bus.calc_s, bus.calc_a, bus.calc_b,
                bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err});
  endfunction
  task automatic load(input int i, input logic [1:0] m, input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
    bus.req_m[2*i +: 2] = m;
    bus.req_s[2*i +: 2] = s;
    bus.req_a[4*i +: 4] = a;
    bus.req_b[4*i +: 4] = b;
  endtask
  task automatic push_exp(input int i);
    logic [1:0] m, s;
    logic [3:0] a, b;
    logic z;
    m = bus.req_m[2*i +: 2];
    s = bus.req_s[2*i +: 2];
    a = bus.req_a[4*i +: 4];
    b = bus.req_b[4*i +: 4];
    z = (m == MODE_DIV) && (b == 4'd0);
    sb.push_back('{id: ID_W'(i), res: z ? 8'h00 : calc(m, s, a, b), err: z});
  endtask
  task automatic wait_gnt(input int i, input string tag);
    for (int n = 0; n < 50 && bus.gnt == '0; n++) @(negedge clk);
    check(tag, 32'(bus.gnt), 32'(1) << i);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || bus.busy) && n < 100);
    check({tag, "_drain"}, 32'(sb.size()), 0);
  endtask
  // engine model: answers each calc_start after eng_k cycles with the true signed result
  initial begin
    logic [7:0] r;
    bus.calc_done = 1'b0;
    bus.calc_result = '0;
    forever begin
      @(negedge clk);
      if (bus.calc_start) begin
        r = calc(bus.calc_m, bus.calc_s, bus.calc_a, bus.calc_b);
        repeat (eng_k - 1) @(negedge clk);
        bus.calc_done = 1'b1;
        bus.calc_result = r;
        @(negedge clk);
        bus.calc_done = 1'b0;
        bus.calc_result = '0;
      end
    end
  end
  always @(negedge clk) begin
    if (bus.gnt != '0) begin
      check("gnt_onehot", 32'($onehot(bus.gnt)), 1);
      g_cyc = cyc;
      gcyc_q.push_back(cyc);
      for (int i = 0; i < NUM_REQ; i++) if (bus.gnt[i]) gnt_q.push_back(i);
    end
    if (bus.calc_start) begin
      starts++;
      s_cyc = cyc;
    end
    if (bus.rsp_valid) begin
      r_cyc = cyc;
      if (sb.size() == 0) check("rsp_unexpected", 32'(bus.rsp_valid), 0);
      else begin
        e = sb.pop_front();
        check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        check("rsp_result", 32'(bus.rsp_result), 32'(e.res));
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.req = '0;
    bus.req_m = '0;
    bus.req_s = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), 0);
    Clear = 1'b0;
    eng_k = 3;
    st = starts;
    load(1, MODE_ADD, 2'b00, 4'd3, 4'd4);
    push_exp(1);
    bus.req[1] = 1'b1;
    wait_gnt(1, "t1_gnt");
    bus.req[1] = 1'b0;
    wait_idle("t1");
    check("t1_starts", 32'(starts - st), 1);
    check("t1_start_lat", 32'(s_cyc - g_cyc), 1);
    check("t1_rsp_lat", 32'(r_cyc - s_cyc), 4);
    st = starts;
    load(2, MODE_DIV, 2'b10, 4'd5, 4'd0);
    push_exp(2);
    bus.req[2] = 1'b1;
    wait_gnt(2, "t2_gnt");
    bus.req[2] = 1'b0;
    wait_idle("t2");
    check("t2_starts", 32'(starts - st), 0);
    check("t2_rsp_lat", 32'(r_cyc - g_cyc), 2);
    Clear = 1'b1;
    @(negedge clk);
    Clear = 1'b0;
    eng_k = 1;
    gnt_q.delete();
    gcyc_q.delete();
    for (int i = 0; i < NUM_REQ; i++) load(i, 2'(i), 2'(i), 4'(i + 2), 4'(i + 1));
    for (int j = 0; j < 5; j++) push_exp(j % NUM_REQ);
    bus.req = '1;
    for (int n = 0; n < 200 && gnt_q.size() < 5; n++) @(negedge clk);
    bus.req = '0;
    wait_idle("t3");
    for (int j = 0; j < 5; j++) check("t3_order", (j < gnt_q.size()) ? 32'(gnt_q[j]) : 32'hFFFF, 32'(j % NUM_REQ));
    for (int j = 1; j < 5; j++) check("t3_gap", (j < gcyc_q.size()) ? 32'(gcyc_q[j] - gcyc_q[j-1]) : 32'hFFFF, 4);
    eng_k = TIMEOUT + 1;
    load(0, MODE_ADD, 2'b00, 4'd1, 4'd1);
    sb.push_back('{id: ID_W'(0), res: 8'h00, err: 1'b1});
    bus.req[0] = 1'b1;
    wait_gnt(0, "t4_gnt");
    bus.req[0] = 1'b0;
    wait_idle("t4");
    repeat (4) @(negedge clk);
    check("t4_timeout_lat", 32'(r_cyc - s_cyc), TIMEOUT + 1);
    eng_k = TIMEOUT;
    load(1, MODE_MUL, 2'b01, 4'd2, 4'd3);
    push_exp(1);
    bus.req[1] = 1'b1;
    wait_gnt(1, "t5_gnt");
    bus.req[1] = 1'b0;
    wait_idle("t5");
    check("t5_race_lat", 32'(r_cyc - s_cyc), TIMEOUT + 1);
    eng_k = 4;
    load(2, MODE_ADD, 2'b00, 4'd1, 4'd1);
    bus.req[2] = 1'b1;
    wait_gnt(2, "t6_first_gnt");
    bus.req[2] = 1'b0;
    repeat (2) @(negedge clk);
    #2 Clear = 1'b1;
    #1 check("t6_async_clr", outs(), 0);
    @(negedge clk);
    Clear = 1'b0;
    st = starts;
    repeat (6) @(negedge clk);
    load(3, MODE_SUB, 2'b00, 4'd7, 4'd2);
    push_exp(3);
    bus.req[3] = 1'b1;
    wait_gnt(3, "t6_gnt");
    bus.req[3] = 1'b0;
    wait_idle("t6");
    check("t6_starts", 32'(starts - st), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
